// File: rtl/io_bamse.sv
// Memory-mapped GPIO for the Pacoblaze bus: port A input with interrupt-on-change, port B input, port C output.
// Define IO_BAMSE_IOC_EN to build the port A interrupt-on-change logic; without it interrupt is tied low.
module io_bamse #(
    parameter int         PORTA_IN_WIDTH     = 3,
    parameter int         PORTB_IN_WIDTH     = 8,
    parameter int         PORTC_OUT_WIDTH    = 8,
    parameter logic [7:0] PORTA_IN           = 8'h01,
    parameter logic [7:0] PORTB_IN           = 8'h02,
    parameter logic [7:0] PORTC_OUT          = 8'h03,
    parameter logic [7:0] PORTA_IOC_POS_CONF = 8'h04,
    parameter logic [7:0] PORTA_IOC_NEG_CONF = 8'h05
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTA_IN_WIDTH-1:0]  PortA,
    input  logic [PORTB_IN_WIDTH-1:0]  PortB,
    output logic [PORTC_OUT_WIDTH-1:0] PortC,
    input  logic [7:0]                 port_id,
    input  logic [7:0]                 port_in,
    output logic [7:0]                 port_out,
    input  logic                       wen,
    input  logic                       ren,
    output logic                       interrupt
);

    logic [PORTA_IN_WIDTH-1:0] porta_meta;
    logic [PORTA_IN_WIDTH-1:0] porta_sync;
    logic [PORTB_IN_WIDTH-1:0] portb_meta;
    logic [PORTB_IN_WIDTH-1:0] portb_sync;

    // Both input ports are asynchronous to clk and get a two-flop synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            porta_meta <= '0;
            porta_sync <= '0;
            portb_meta <= '0;
            portb_sync <= '0;
            PortC      <= '0;
        end else begin
            porta_meta <= PortA;
            porta_sync <= porta_meta;
            portb_meta <= PortB;
            portb_sync <= portb_meta;
            if (wen && (port_id == PORTC_OUT))
                PortC <= port_in[PORTC_OUT_WIDTH-1:0];
        end
    end

`ifdef IO_BAMSE_IOC_EN
    logic [PORTA_IN_WIDTH-1:0] porta_prev;
    logic [PORTA_IN_WIDTH-1:0] pos_mask;
    logic [PORTA_IN_WIDTH-1:0] neg_mask;
    logic [PORTA_IN_WIDTH-1:0] ioc_flags;
    logic [PORTA_IN_WIDTH-1:0] ioc_events;
    logic [PORTA_IN_WIDTH-1:0] flags_next;
    logic                      flag_clear;

    assign ioc_events = (porta_sync & ~porta_prev & pos_mask)
                      | (~porta_sync & porta_prev & neg_mask);
    assign flag_clear = ren && (port_id == PORTA_IN);
    // A new event on the same edge as the clearing read wins over the clear.
    assign flags_next = (flag_clear ? '0 : ioc_flags) | ioc_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            porta_prev <= '0;
            pos_mask   <= '0;
            neg_mask   <= '0;
            ioc_flags  <= '0;
            interrupt  <= 1'b0;
        end else begin
            porta_prev <= porta_sync;
            ioc_flags  <= flags_next;
            interrupt  <= |flags_next;
            if (wen && (port_id == PORTA_IOC_POS_CONF))
                pos_mask <= port_in[PORTA_IN_WIDTH-1:0];
            if (wen && (port_id == PORTA_IOC_NEG_CONF))
                neg_mask <= port_in[PORTA_IN_WIDTH-1:0];
        end
    end
`else
    logic unused_ren;
    assign unused_ren = ren;
    assign interrupt  = 1'b0;
`endif

    always_comb begin
        port_out = 8'h00;
        case (port_id)
            PORTA_IN: begin
                port_out[PORTA_IN_WIDTH-1:0] = porta_sync;
`ifdef IO_BAMSE_IOC_EN
                port_out[PORTA_IN_WIDTH+3:4] = ioc_flags;
`endif
            end
            PORTB_IN:  port_out[PORTB_IN_WIDTH-1:0]  = portb_sync;
            PORTC_OUT: port_out[PORTC_OUT_WIDTH-1:0] = PortC;
`ifdef IO_BAMSE_IOC_EN
            PORTA_IOC_POS_CONF: port_out[PORTA_IN_WIDTH-1:0] = pos_mask;
            PORTA_IOC_NEG_CONF: port_out[PORTA_IN_WIDTH-1:0] = neg_mask;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_bamse.sv
// Self-checking bench for io_bamse: register table, hand-written IOC sequences, then randomized traffic against a reference model.
module tb_io_bamse;

`ifdef IO_BAMSE_IOC_EN
    localparam bit IOC = 1'b1;
`else
    localparam bit IOC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] PortA = '0;
    logic [7:0] PortB = '0;
    logic [7:0] PortC;
    logic [7:0] port_id = '0;
    logic [7:0] port_in = '0;
    logic [7:0] port_out;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       interrupt;

    int pass_cnt = 0;
    int total_cnt = 0;

    io_bamse dut (
        .clk(clk), .rst(rst), .PortA(PortA), .PortB(PortB), .PortC(PortC),
        .port_id(port_id), .port_in(port_in), .port_out(port_out),
        .wen(wen), .ren(ren), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    // Reference model: pin samples seen at successive edges, newest first.
    logic [2:0] ha [3];
    logic [7:0] hb [2];
    logic [2:0] m_pos, m_neg, m_flags;
    logic [7:0] m_c;
    logic       m_int;

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            8'h01: begin
                r[2:0] = ha[1];
                if (IOC) r[6:4] = m_flags;
            end
            8'h02: r = hb[1];
            8'h03: r = m_c;
            8'h04: if (IOC) r[2:0] = m_pos;
            8'h05: if (IOC) r[2:0] = m_neg;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        logic [2:0] ev;
        logic [2:0] nf;
        if (rst) begin
            ha[0] = '0; ha[1] = '0; ha[2] = '0;
            hb[0] = '0; hb[1] = '0;
            m_pos = '0; m_neg = '0; m_flags = '0; m_c = '0; m_int = 1'b0;
        end else begin
            ev = '0;
            for (int i = 0; i < 3; i++) begin
                if (IOC && ((ha[1][i] && !ha[2][i] && m_pos[i]) ||
                            (!ha[1][i] && ha[2][i] && m_neg[i])))
                    ev[i] = 1'b1;
            end
            nf = ((ren && port_id == 8'h01) ? 3'b000 : m_flags) | ev;
            if (wen) begin
                if (port_id == 8'h03) m_c = port_in;
                if (IOC && port_id == 8'h04) m_pos = port_in[2:0];
                if (IOC && port_id == 8'h05) m_neg = port_in[2:0];
            end
            m_flags = nf;
            m_int = (nf != 3'b000);
            ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = PortA;
            hb[1] = hb[0]; hb[0] = PortB;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        port_id = a; port_in = d; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
        port_id = a;
        #1;
        check(name, port_out, exp);
    endtask

    // Reads PORTA_IN (checking the value) and strobes ren, which clears the flags.
    task automatic read_clr(input string name, input logic [7:0] exp);
        peek(name, 8'h01, exp);
        ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       do_wr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{8'h04, 8'h03, 1'b1, IOC ? 8'h03 : 8'h00};
        vecs[1] = '{8'h05, 8'h05, 1'b1, IOC ? 8'h05 : 8'h00};
        vecs[2] = '{8'h06, 8'hFF, 1'b1, 8'h00};
        vecs[3] = '{8'h03, 8'h5A, 1'b1, 8'h5A};
        vecs[4] = '{8'h03, 8'h00, 1'b1, 8'h00};
        vecs[5] = '{8'h01, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{8'h02, 8'h00, 1'b0, 8'h00};

        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        check("reset_int", {7'b0, interrupt}, 8'h00);
        check("reset_portc", PortC, 8'h00);
        peek("reset_pos", 8'h04, 8'h00);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_wr) write_reg(vecs[i].addr, vecs[i].wdata);
            peek($sformatf("table_%0d", i), vecs[i].addr, vecs[i].exp);
        end
        check("mask_int", {7'b0, interrupt}, 8'h00);

`ifdef IO_BAMSE_IOC_EN
        PortA = 3'b001; ticks(2);
        check("b0r_latency", {7'b0, interrupt}, 8'h00);
        tick();
        check("b0r_int", {7'b0, interrupt}, 8'h01);
        read_clr("b0r_read", 8'h11);
        check("b0r_clr", {7'b0, interrupt}, 8'h00);

        PortA = 3'b000; ticks(3);
        check("b0f_int", {7'b0, interrupt}, 8'h01);
        read_clr("b0f_read", 8'h10);
        check("b0f_clr", {7'b0, interrupt}, 8'h00);

        PortA = 3'b010; ticks(3);
        check("b1r_int", {7'b0, interrupt}, 8'h01);
        read_clr("b1r_read", 8'h22);
        PortA = 3'b000; ticks(4);
        check("b1f_int", {7'b0, interrupt}, 8'h00);
        read_clr("b1f_read", 8'h00);

        PortA = 3'b100; ticks(4);
        check("b2r_int", {7'b0, interrupt}, 8'h00);
        read_clr("b2r_read", 8'h04);
        PortA = 3'b000; ticks(3);
        check("b2f_int", {7'b0, interrupt}, 8'h01);
        read_clr("b2f_read", 8'h40);
        check("b2f_clr", {7'b0, interrupt}, 8'h00);
`else
        PortA = 3'b101; ticks(3);
        peek("noioc_pins", 8'h01, 8'h05);
        check("noioc_int", {7'b0, interrupt}, 8'h00);
        PortA = 3'b000; ticks(3);
`endif

        PortB = 8'hBB; tick();
        peek("portb_early", 8'h02, 8'h00);
        tick();
        peek("portb_read", 8'h02, 8'hBB);
        write_reg(8'h03, 8'hCC);
        check("portc_pin", PortC, 8'hCC);
        peek("portc_read", 8'h03, 8'hCC);
        peek("unmapped", 8'h07, 8'h00);

`ifdef IO_BAMSE_IOC_EN
        // Event lands on the same edge as the clearing read.
        PortA = 3'b001; ticks(2);
        port_id = 8'h01; ren = 1'b1;
        tick();
        ren = 1'b0;
        check("sbc_int", {7'b0, interrupt}, 8'h01);
        peek("sbc_read", 8'h01, 8'h11);
`endif

        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_int", {7'b0, interrupt}, 8'h00);
        check("rst_portc", PortC, 8'h00);
        peek("rst_pos", 8'h04, 8'h00);
        peek("rst_neg", 8'h05, 8'h00);
        peek("rst_porta", 8'h01, 8'h00);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) PortA = 3'($urandom);
            PortB   = 8'($urandom);
            port_id = 8'($urandom_range(0, 7));
            port_in = 8'($urandom);
            wen     = ($urandom_range(0, 3) == 0);
            ren     = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            #1;
            check($sformatf("rnd_rd_%0d", n), port_out, model_read(port_id));
            tick();
            check($sformatf("rnd_int_%0d", n), {7'b0, interrupt}, {7'b0, m_int});
            check($sformatf("rnd_pc_%0d", n), PortC, m_c);
        end
        wen = 1'b0; ren = 1'b0; rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/io_bamse.md
Name: io_bamse

Overview:
- Memory-mapped GPIO peripheral for the Pacoblaze (PicoBlaze-compatible) core.
- Provides:
  - 3-bit input port A with per-bit interrupt-on-change (IOC). Rising-edge and falling-edge detection are enabled independently per bit.
  - 8-bit input port B.
  - 8-bit registered output port C.
- Sits between the core's port_id/in/out/strobe bus and the chip pins.
- Drives the core's interrupt input.

Parameters:
- PORTA_IN_WIDTH, 3, port A width; legal range 1..4.
- PORTB_IN_WIDTH, 8, port B width; legal range 1..8.
- PORTC_OUT_WIDTH, 8, port C width; legal range 1..8.
- PORTA_IN, 8'h01, address: port A pins and IOC flags (read; the read clears the flags).
- PORTB_IN, 8'h02, address: port B pins (read).
- PORTC_OUT, 8'h03, address: port C register (read/write).
- PORTA_IOC_POS_CONF, 8'h04, address: rising-edge enable mask (read/write).
- PORTA_IOC_NEG_CONF, 8'h05, address: falling-edge enable mask (read/write).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PortA  in  PORTA_IN_WIDTH  port A pins; asynchronous to clk.
- PortB  in  PORTB_IN_WIDTH  port B pins; asynchronous to clk.
- PortC  out  PORTC_OUT_WIDTH  port C output register.
- port_id  in  8  bus address from the core.
- port_in  in  8  write data from the core's OUTPUT instruction.
- port_out  out  8  read data to the core's INPUT instruction.
- wen  in  1  write strobe, one cycle.
- ren  in  1  read strobe, one cycle.
- interrupt  out  1  level interrupt request to the core.

Behaviour:
- Reset (rst high at a clock edge) clears all of the following to 0:
  - PortC
  - POS and NEG masks
  - IOC flags
  - both synchronizer stages and the previous-sample register
  - interrupt
- Reset overrides any same-cycle write, read or edge event.
- Writes:
  - On a clock edge with wen=1, port_id selects the target register. PORTC_OUT, POS_CONF and NEG_CONF each load the low bits of port_in.
  - Writes to any other address are ignored.
  - A write is visible on PortC one cycle after the edge.
- Reads:
  - port_out is combinational on port_id.
  - PORTA_IN returns {zero pad, flags[W-1:0] in bits [W+3:4], synchronized pins[W-1:0] in bits [W-1:0]}. For W=3 the value is {1'b0, flags, 1'b0, pins}.
  - PORTB_IN returns the synchronized PortB, zero-extended to 8 bits.
  - PORTC_OUT, POS_CONF and NEG_CONF return their register values, zero-extended.
  - All other addresses return 8'h00.
  - ren has no effect on port_out.
- Synchronization: PortA and PortB each pass through a 2-flop synchronizer. A third register holds the previous synchronized PortA sample.
- Edge detection, for each bit i:
  - rise_i = sync_i & ~prev_i & POS_i
  - fall_i = ~sync_i & prev_i & NEG_i
  - flag_i is set on the next clock edge when (rise_i | fall_i) is true.
  - Latency: PortA change to flag/interrupt high is 3 clock edges.
- Flag clear: on a clock edge with ren=1 and port_id==PORTA_IN, all flags are cleared.
  - If an edge event occurs in the same cycle as the clear, that bit's flag is set: set beats clear.
- interrupt is registered and equals the OR of the flags.
  - It deasserts the cycle after the clearing read, unless a new event is pending.
- Mask changes:
  - Do not clear existing flags.
  - A mask bit of 0 suppresses only new events on that bit.
- wen and ren in the same cycle are handled independently.

Optional Feature:
- Macro: IO_BAMSE_IOC_EN.
- Defined: IOC logic as described above.
- Undefined:
  - The masks, flags and previous-sample register are not built.
  - interrupt is tied to 0.
  - POS_CONF and NEG_CONF behave as unmapped: writes ignored, reads return 8'h00.
  - PORTA_IN returns the zero-extended synchronized pins only.

Test Plan (all scenarios with IO_BAMSE_IOC_EN defined, after reset):
- Mask setup and readback: write POS_CONF=3'b011 and NEG_CONF=3'b101 -> reads return 8'h03 and 8'h05; interrupt stays 0.
- Bit 0 edges (masks as above):
  - PortA 000->001 -> interrupt=1 within 3 clocks; PORTA_IN read returns 8'h11; interrupt=0 the cycle after ren.
  - PortA 001->000 -> interrupt=1; read returns 8'h10.
- Bit 1 edges: PortA 000->010 -> interrupt=1, read 8'h22; PortA back to 000 -> NEG_1=0, so interrupt stays 0 and a read returns 8'h00.
- Bit 2 edges: PortA 000->100 -> POS_2=0, so no interrupt, read 8'h04; PortA back to 000 -> interrupt=1, read 8'h40, interrupt then clears.
- Port B and port C:
  - PortB=8'hBB -> PORTB_IN read returns 8'hBB after 2 clocks.
  - Write PORTC_OUT=8'hCC -> PortC=8'hCC one cycle later; read back 8'hCC; an unmapped address reads 8'h00.
- Reset and set-beats-clear:
  - rst while a flag is pending -> interrupt, flags, masks and PortC all return to 0.
  - An edge event coinciding with a PORTA_IN read strobe leaves that bit's flag set.
